// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory/IO bus between instruction fetch (port 0)
// and data load/store (port 1); one transaction at a time, acked with a single pulse.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_din,
  input  logic [3:0]        p0_we,
  input  logic              p0_load,
  output logic              p0_ack,
  output logic [31:0]       p0_dout,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_din,
  input  logic [3:0]        p1_we,
  input  logic              p1_load,
  output logic              p1_ack,
  output logic [31:0]       p1_dout,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_din,
  output logic [3:0]        m_write_enable,
  output logic              m_load,
  input  logic [31:0]       m_dout,
  input  logic              m_done,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic RR = (FIXED_PRIO == 0);

  state_t            r_state;
  logic              r_last;
  logic              r_win;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       r_m_din;
  logic [3:0]        r_m_we;
  logic              r_m_load;
  logic [1:0]        r_grant;
  logic              r_busy;
  logic              r_p0_ack;
  logic              r_p1_ack;
  logic [31:0]       r_p0_dout;
  logic [31:0]       r_p1_dout;

  logic w_any;
  logic w_pick1;

  // Port 1 wins when alone, or on a tie under round-robin if port 0 was served last.
  assign w_any   = p0_req | p1_req;
  assign w_pick1 = p1_req & (~p0_req | (RR & ~r_last));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_m_addr  <= '0;
      r_m_din   <= '0;
      r_m_we    <= '0;
      r_m_load  <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_p0_ack  <= 1'b0;
      r_p1_ack  <= 1'b0;
      r_p0_dout <= '0;
      r_p1_dout <= '0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win    <= w_pick1;
            r_m_addr <= w_pick1 ? p1_addr : p0_addr;
            r_m_din  <= w_pick1 ? p1_din  : p0_din;
            r_m_we   <= w_pick1 ? p1_we   : p0_we;
            r_m_load <= w_pick1 ? p1_load : p0_load;
            r_grant  <= w_pick1 ? 2'b10 : 2'b01;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        // A done level left over from the previous access is not trusted here.
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (m_done) begin
            if (r_win) begin
              r_p1_dout <= m_dout;
              r_p1_ack  <= 1'b1;
            end else begin
              r_p0_dout <= m_dout;
              r_p0_ack  <= 1'b1;
            end
            r_last   <= r_win;
            r_m_we   <= '0;
            r_m_load <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_m_addr <= '0;
          r_m_din  <= '0;
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_addr         = r_m_addr;
  assign m_din          = r_m_din;
  assign m_write_enable = r_m_we;
  assign m_load         = r_m_load;
  assign grant          = r_grant;
  assign busy           = r_busy;
  assign p0_ack         = r_p0_ack;
  assign p1_ack         = r_p1_ack;
  assign p0_dout        = r_p0_dout;
  assign p1_dout        = r_p1_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (a) and a fixed-priority instance (b)
// share stimulus; completions are checked against per-instance expectation queues.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        p0_req = 0, p0_load = 0, p1_req = 0, p1_load = 0, m_done = 0;
  logic [31:0] p0_addr = 0, p0_din = 0, p1_addr = 0, p1_din = 0, m_dout = 0;
  logic [3:0]  p0_we = 0, p1_we = 0;

  logic        p0_ack_a, p1_ack_a, m_load_a, busy_a;
  logic [31:0] p0_dout_a, p1_dout_a, m_addr_a, m_din_a;
  logic [3:0]  m_we_a;
  logic [1:0]  grant_a;
  logic        p0_ack_b, p1_ack_b, m_load_b, busy_b;
  logic [31:0] p0_dout_b, p1_dout_b, m_addr_b, m_din_b;
  logic [3:0]  m_we_b;
  logic [1:0]  grant_b;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0), .ADDR_W(32)) dut_a (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_din(p0_din), .p0_we(p0_we), .p0_load(p0_load),
    .p0_ack(p0_ack_a), .p0_dout(p0_dout_a),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_din(p1_din), .p1_we(p1_we), .p1_load(p1_load),
    .p1_ack(p1_ack_a), .p1_dout(p1_dout_a),
    .m_addr(m_addr_a), .m_din(m_din_a), .m_write_enable(m_we_a), .m_load(m_load_a),
    .m_dout(m_dout), .m_done(m_done), .grant(grant_a), .busy(busy_a)
  );

  mem_arbiter #(.FIXED_PRIO(1), .ADDR_W(32)) dut_b (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_din(p0_din), .p0_we(p0_we), .p0_load(p0_load),
    .p0_ack(p0_ack_b), .p0_dout(p0_dout_b),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_din(p1_din), .p1_we(p1_we), .p1_load(p1_load),
    .p1_ack(p1_ack_b), .p1_dout(p1_dout_b),
    .m_addr(m_addr_b), .m_din(m_din_b), .m_write_enable(m_we_b), .m_load(m_load_b),
    .m_dout(m_dout), .m_done(m_done), .grant(grant_b), .busy(busy_b)
  );

  // Scoreboard side: every ack pops one expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (p0_ack_a || p1_ack_a) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL ack_a_unexpected p0_ack=%0b p1_ack=%0b required none", p0_ack_a, p1_ack_a);
      end else begin
        e = q_a.pop_front();
        if ((p0_ack_a && p1_ack_a) || (p1_ack_a !== e.port) ||
            ((e.port ? p1_dout_a : p0_dout_a) !== e.data)) begin
          failures++;
          $display("FAIL ack_a acks=%b%b dout0=%h dout1=%h required port=%0d data=%h",
                   p1_ack_a, p0_ack_a, p0_dout_a, p1_dout_a, e.port, e.data);
        end else
          $display("ack dut=a port=%0d data=%h", e.port, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (p0_ack_b || p1_ack_b) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL ack_b_unexpected p0_ack=%0b p1_ack=%0b required none", p0_ack_b, p1_ack_b);
      end else begin
        e = q_b.pop_front();
        if ((p0_ack_b && p1_ack_b) || (p1_ack_b !== e.port) ||
            ((e.port ? p1_dout_b : p0_dout_b) !== e.data)) begin
          failures++;
          $display("FAIL ack_b acks=%b%b dout0=%h dout1=%h required port=%0d data=%h",
                   p1_ack_b, p0_ack_b, p0_dout_b, p1_dout_b, e.port, e.data);
        end else
          $display("ack dut=b port=%0d data=%h", e.port, e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic port_a, input logic port_b, input logic [31:0] data);
    q_a.push_back('{port: port_a, data: data});
    q_b.push_back('{port: port_b, data: data});
  endtask

  task automatic test_reset;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({p0_ack_a, p1_ack_a, grant_a, busy_a, m_we_a, m_load_a, m_addr_a, m_din_a,
         p0_dout_a, p1_dout_a, grant_b, busy_b} !== '0) begin
      failures++;
      $display("FAIL reset_state grant=%b busy=%b we=%b load=%b addr=%h required all zero",
               grant_a, busy_a, m_we_a, m_load_a, m_addr_a);
    end
    tick;
    rstn = 1'b1;
  endtask

  task automatic test_round_robin;
    logic exp_port;
    p0_req = 1; p0_addr = 32'h10; p0_load = 1;
    p1_req = 1; p1_addr = 32'h20; p1_load = 1;
    m_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_port = i[0];
      checks++;
      if (grant_a !== (exp_port ? 2'b10 : 2'b01) || m_addr_a !== (exp_port ? 32'h20 : 32'h10)) begin
        failures++;
        $display("FAIL rr_grant txn=%0d grant=%b addr=%h required port=%0d", i, grant_a, m_addr_a, exp_port);
      end
      checks++;
      if (grant_b !== 2'b01 || m_addr_b !== 32'h10) begin
        failures++;
        $display("FAIL fixed_grant txn=%0d grant=%b addr=%h required 01/10", i, grant_b, m_addr_b);
      end
      m_dout = 32'hA000_0000 | i;
      push_exp(exp_port, 1'b0, m_dout);
      tick; tick; tick;
      checks++;
      if ({grant_a, busy_a, grant_b, busy_b} !== '0) begin
        failures++;
        $display("FAIL rr_idle txn=%0d grant=%b busy=%b required 00/0", i, grant_a, busy_a);
      end
    end
    p0_req = 0; p1_req = 0; p0_load = 0; p1_load = 0; m_done = 0;
  endtask

  task automatic test_single_read;
    p0_req = 1; p0_addr = 32'h100; p0_load = 1; m_dout = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 32'hDEADBEEF);
    tick;
    checks++;
    if (m_addr_a !== 32'h100 || m_load_a !== 1'b1 || grant_a !== 2'b01 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL read_issue addr=%h load=%b grant=%b required 100/1/01", m_addr_a, m_load_a, grant_a);
    end
    m_done = 1;
    tick;
    checks++;
    if (m_addr_a !== 32'h100 || m_load_a !== 1'b1 || p0_ack_a !== 1'b0) begin
      failures++;
      $display("FAIL read_wait addr=%h load=%b ack=%b required 100/1/0", m_addr_a, m_load_a, p0_ack_a);
    end
    tick;
    checks++;
    if (p0_ack_a !== 1'b1 || m_load_a !== 1'b0 || m_addr_a !== 32'h100 || grant_a !== 2'b01) begin
      failures++;
      $display("FAIL read_done ack=%b load=%b addr=%h grant=%b required 1/0/100/01",
               p0_ack_a, m_load_a, m_addr_a, grant_a);
    end
    p0_req = 0; p0_load = 0; m_done = 0;
    tick;
    checks++;
    if (p0_ack_a !== 1'b0 || busy_a !== 1'b0 || m_addr_a !== 32'h0 || p0_dout_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_idle ack=%b busy=%b addr=%h dout=%h required 0/0/0/deadbeef",
               p0_ack_a, busy_a, m_addr_a, p0_dout_a);
    end
  endtask

  task automatic test_stalled_write;
    int bad = 0;
    p1_req = 1; p1_addr = 32'h10004; p1_we = 4'b0001; p1_din = 32'h41000000; m_done = 0;
    tick;
    checks++;
    if (m_we_a !== 4'b0001 || m_addr_a !== 32'h10004 || m_din_a !== 32'h41000000 || grant_a !== 2'b10) begin
      failures++;
      $display("FAIL write_issue we=%b addr=%h din=%h grant=%b required 0001/10004/41000000/10",
               m_we_a, m_addr_a, m_din_a, grant_a);
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      if (m_we_a !== 4'b0001 || p1_ack_a !== 1'b0 || busy_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_stall bad_cycles=%0d required 0", bad);
    end
    m_dout = 32'h12345678; m_done = 1;
    push_exp(1'b1, 1'b1, 32'h12345678);
    tick;
    checks++;
    if (p1_ack_a !== 1'b1 || m_we_a !== 4'b0000 || m_addr_a !== 32'h10004 || p0_dout_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_done ack=%b we=%b addr=%h p0_dout=%h required 1/0000/10004/deadbeef",
               p1_ack_a, m_we_a, m_addr_a, p0_dout_a);
    end
    p1_req = 0; p1_we = 0; m_done = 0;
    tick;
    checks++;
    if (p1_ack_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL write_idle ack=%b busy=%b required 0/0", p1_ack_a, busy_a);
    end
  endtask

  task automatic test_stale_done;
    m_done = 1; m_dout = 32'h5555AAAA;
    p0_req = 1; p0_addr = 32'h40; p0_load = 1;
    push_exp(1'b0, 1'b0, 32'h5555AAAA);
    tick;
    tick;
    checks++;
    if (p0_ack_a !== 1'b0 || m_load_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL stale_done ack=%b load=%b required 0/1 after issue", p0_ack_a, m_load_a);
    end
    tick;
    checks++;
    if (p0_ack_a !== 1'b1) begin
      failures++;
      $display("FAIL stale_complete ack=%b required 1", p0_ack_a);
    end
    p0_req = 0; p0_load = 0; m_done = 0;
    tick;
  endtask

  task automatic test_field_change;
    p0_req = 1; p0_addr = 32'h200; p0_load = 1; m_done = 0;
    tick;
    tick;
    p0_addr = 32'h300; p0_load = 0; p0_we = 4'hF;
    tick;
    checks++;
    if (m_addr_a !== 32'h200 || m_load_a !== 1'b1 || m_we_a !== 4'b0000) begin
      failures++;
      $display("FAIL field_hold addr=%h load=%b we=%b required 200/1/0000", m_addr_a, m_load_a, m_we_a);
    end
    m_dout = 32'h0000_0200; m_done = 1;
    push_exp(1'b0, 1'b0, 32'h0000_0200);
    tick;
    checks++;
    if (m_addr_a !== 32'h200 || p0_ack_a !== 1'b1) begin
      failures++;
      $display("FAIL field_done addr=%h ack=%b required 200/1", m_addr_a, p0_ack_a);
    end
    p0_req = 0; p0_we = 0; m_done = 0;
    tick;
  endtask

  task automatic test_async_reset;
    p1_req = 1; p1_addr = 32'h80; p1_we = 4'hF; p1_din = 32'hCAFE0001; m_done = 0;
    tick;
    tick;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({m_we_a, m_load_a, grant_a, busy_a, p1_ack_a, m_we_b, grant_b, busy_b} !== '0) begin
      failures++;
      $display("FAIL async_reset we=%b grant=%b busy=%b ack=%b required all zero",
               m_we_a, grant_a, busy_a, p1_ack_a);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    tick;
    checks++;
    if (grant_a !== 2'b10 || m_we_a !== 4'hF || m_addr_a !== 32'h80 || grant_b !== 2'b10) begin
      failures++;
      $display("FAIL post_reset_issue grant=%b we=%b addr=%h required 10/f/80", grant_a, m_we_a, m_addr_a);
    end
    m_dout = 32'h0BADF00D; m_done = 1;
    push_exp(1'b1, 1'b1, 32'h0BADF00D);
    tick;
    tick;
    checks++;
    if (p1_ack_a !== 1'b1 || p1_dout_a !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL post_reset_done ack=%b dout=%h required 1/0badf00d", p1_ack_a, p1_dout_a);
    end
    p1_req = 0; p1_we = 0; m_done = 0;
    tick;
  endtask

  initial begin
    test_reset;
    tick;
    test_round_robin;
    test_single_read;
    test_stalled_write;
    test_stale_done;
    test_field_change;
    test_async_reset;
    tick; tick;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL pending_acks a=%0d b=%0d required 0/0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single core-side memory/IO bus (address, write data, byte write-enable, load strobe, read data, done) between requester 0 (instruction fetch) and requester 1 (data load/store).
- Sits between the requesters and the memory/IO mapping proxy.
- Serialises requests, holds each one stable until the downstream reports done, and returns read data with a one-cycle acknowledge.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request; held high until p0_ack
- p0_addr  in  ADDR_W  port 0 address
- p0_din  in  32  port 0 write data
- p0_we  in  4  port 0 byte write-enable
- p0_load  in  1  port 0 read strobe
- p0_ack  out  1  port 0 transaction complete, one-cycle pulse
- p0_dout  out  32  port 0 read data, valid while p0_ack=1
- p1_req, p1_addr, p1_din, p1_we, p1_load, p1_ack, p1_dout: same widths and meanings for port 1
- m_addr  out  ADDR_W  downstream address
- m_din  out  32  downstream write data
- m_write_enable  out  4  downstream byte write-enable
- m_load  out  1  downstream read strobe
- m_dout  in  32  downstream read data
- m_done  in  1  downstream completion, level
- grant  out  2  one-hot owner of the bus; 0 when idle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - Clock is clk. Reset is asynchronous, active-low (rstn).
  - On reset: state=IDLE, all outputs 0, last-served pointer = port 1 (so port 0 wins the first tie).
  - Reset mid-transaction aborts immediately; m_write_enable and m_load drop to 0 asynchronously. No ack is issued for the aborted request.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - m_* outputs = 0, grant = 0.
  - If any req is high: select a winner, latch its addr/din/we/load into internal registers, set grant, go to ISSUE.
  - Only one req high: that port wins.
  - Both high with FIXED_PRIO=1: port 0 wins.
  - Both high with FIXED_PRIO=0: the port not in the last-served pointer wins; the pointer updates on entry to DONE.
- ISSUE:
  - Lasts exactly 1 cycle; m_* driven from the latched registers.
  - m_done is ignored here, because a stale done from the previous access may still be high.
  - Always go to WAIT.
- WAIT:
  - m_* held from the latched registers.
  - On the first cycle with m_done=1: capture m_dout into the winner's dout register and go to DONE.
  - No timeout; UART-backed accesses may stall indefinitely.
- DONE:
  - Lasts exactly 1 cycle.
  - The winner's ack=1; its dout holds the captured value. The non-winner's ack=0 and its dout is unchanged.
  - m_write_enable=0 and m_load=0; m_addr is held.
  - Go to IDLE.
  - The requester must drop req, or present a new request, at the clock edge ending DONE. Req is re-sampled only in IDLE.
- Requester input changes while that port is granted are ignored, because fields are latched in IDLE.
- Minimum transaction: 4 cycles from IDLE sample to return to IDLE (m_done already high in the first WAIT cycle). Back-to-back requests from both ports alternate under round-robin.
- pN_dout retains its last captured value until that port's next completion. Write transactions also capture m_dout; requesters ignore it.
- A req with we=0 and load=0 is still arbitrated and completed as a no-op access.

Test Plan:
- Single read, port 0: p0_req, addr 0x100, load=1; m_done high from the first WAIT cycle with m_dout=0xDEADBEEF -> m_addr=0x100 and m_load=1 during ISSUE/WAIT; p0_ack one cycle with p0_dout=0xDEADBEEF; grant=01; 4 cycles total.
- Simultaneous requests, FIXED_PRIO=0, both held for three transactions -> served in order port 0, port 1, port 0. With FIXED_PRIO=1 -> port 0 every time, port 1 starved while p0_req stays high.
- Stalled write: p1 writes 0x10004 with we=0001 and din=0x41000000; m_done low for 20 cycles, then high -> m_write_enable=0001 held all 20 cycles; p1_ack exactly 1 cycle after m_done rises; m_write_enable=0 in DONE.
- Stale done: m_done stuck at 1 during ISSUE -> no completion in ISSUE; completion occurs in the following WAIT cycle.
- Async reset: rstn low mid-WAIT -> m_write_enable, m_load, grant, busy = 0 with no clock edge; no ack. After release, a pending p1_req alone is served normally.
- Field change during grant: p0_addr changes from 0x200 to 0x300 while in WAIT -> m_addr stays 0x200 until DONE.
